// File: rtl/ysyx_24110006_axi_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24110006_axi_arbiter_pkg
// Shared definitions for the read arbiter: AXI field widths, requester
// indices and the read-FSM state encoding.
// ----------------------------------------------------------------------------
package ysyx_24110006_axi_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int STRB_W = DATA_W / 8;

  // Requester indices into grant / request vectors.
  localparam int M_IFU = 0;
  localparam int M_LSU = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_WAIT_R = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ysyx_24110006_axi_arbiter_if.sv
// ----------------------------------------------------------------------------
// AXI channel bundles used by the arbiter.
//   ysyx_24110006_axi_arbiter_rd_if : AR + R channels
//   ysyx_24110006_axi_arbiter_wr_if : AW + W + B channels
// Modport master = side that issues requests (drives ar*/aw*/w*, rready,
// bready); modport slave = side that answers them.
// ----------------------------------------------------------------------------
interface ysyx_24110006_axi_arbiter_rd_if;
  logic [ysyx_24110006_axi_arbiter_pkg::ADDR_W-1:0] araddr;
  logic                                             arvalid;
  logic                                             arready;
  logic [ysyx_24110006_axi_arbiter_pkg::ID_W-1:0]   arid;
  logic [ysyx_24110006_axi_arbiter_pkg::LEN_W-1:0]  arlen;
  logic [2:0]                                       arsize;
  logic [1:0]                                       arburst;
  logic [ysyx_24110006_axi_arbiter_pkg::DATA_W-1:0] rdata;
  logic                                             rvalid;
  logic                                             rready;
  logic [1:0]                                       rresp;
  logic [ysyx_24110006_axi_arbiter_pkg::ID_W-1:0]   rid;
  logic                                             rlast;

  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst, rready,
    input  arready, rdata, rvalid, rresp, rid, rlast
  );
  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
    output arready, rdata, rvalid, rresp, rid, rlast
  );
endinterface

interface ysyx_24110006_axi_arbiter_wr_if;
  logic [ysyx_24110006_axi_arbiter_pkg::ADDR_W-1:0] awaddr;
  logic                                             awvalid;
  logic                                             awready;
  logic [ysyx_24110006_axi_arbiter_pkg::ID_W-1:0]   awid;
  logic [ysyx_24110006_axi_arbiter_pkg::LEN_W-1:0]  awlen;
  logic [2:0]                                       awsize;
  logic [1:0]                                       awburst;
  logic [ysyx_24110006_axi_arbiter_pkg::DATA_W-1:0] wdata;
  logic [ysyx_24110006_axi_arbiter_pkg::STRB_W-1:0] wstrb;
  logic                                             wlast;
  logic                                             wvalid;
  logic                                             wready;
  logic                                             bvalid;
  logic                                             bready;
  logic [1:0]                                       bresp;
  logic [ysyx_24110006_axi_arbiter_pkg::ID_W-1:0]   bid;

  modport master (
    output awaddr, awvalid, awid, awlen, awsize, awburst,
           wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bvalid, bresp, bid
  );
  modport slave (
    input  awaddr, awvalid, awid, awlen, awsize, awburst,
           wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/ysyx_24110006_axi_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// ysyx_24110006_rr_pick
// Combinational winner selection for two read requesters.
//   req_i  : request vector (bit M_IFU / M_LSU)
//   last_i : one-hot index of the previous winner
//   gnt_o  : one-hot winner, 0 when nobody requests
// RR_EN=1: the requester after last_i is tried first.
// RR_EN=0: fixed priority, LSU before IFU.
// ----------------------------------------------------------------------------
module ysyx_24110006_rr_pick
  import ysyx_24110006_axi_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic [1:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] gnt_o
);

  logic ifu_first;

  // IFU only goes first when rotating and the LSU won last time.
  assign ifu_first = (RR_EN != 0) && last_i[M_LSU];

  always_comb begin
    gnt_o = '0;
    if (ifu_first) begin
      if (req_i[M_IFU])      gnt_o[M_IFU] = 1'b1;
      else if (req_i[M_LSU]) gnt_o[M_LSU] = 1'b1;
    end else begin
      if (req_i[M_LSU])      gnt_o[M_LSU] = 1'b1;
      else if (req_i[M_IFU]) gnt_o[M_IFU] = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_24110006_axi_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_24110006_axi_arbiter
// Arbitrates the read channels of IFU (M0) and LSU (M1) onto one downstream
// AXI master port; the LSU write channels pass straight through, except that
// an AW is held while the LSU owns a read of the same address.
// Ports:
//   i_clock, i_reset (async, active-low)
//   m0_rd  : IFU AR/R (slave side)
//   m1_rd  : LSU AR/R (slave side)
//   m1_wr  : LSU AW/W/B (slave side)
//   axi_rd : downstream AR/R (master side)
//   axi_wr : downstream AW/W/B (master side)
//   o_rd_grant : one-hot current read owner, 0 when idle
// Only NUM_M = 2 is supported.
// ----------------------------------------------------------------------------
module ysyx_24110006_axi_arbiter
  import ysyx_24110006_axi_arbiter_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int RR_EN = 1
) (
  input  logic                                  i_clock,
  input  logic                                  i_reset,
  ysyx_24110006_axi_arbiter_rd_if.slave         m0_rd,
  ysyx_24110006_axi_arbiter_rd_if.slave         m1_rd,
  ysyx_24110006_axi_arbiter_wr_if.slave         m1_wr,
  ysyx_24110006_axi_arbiter_rd_if.master        axi_rd,
  ysyx_24110006_axi_arbiter_wr_if.master        axi_wr,
  output logic [NUM_M-1:0]                      o_rd_grant
);

  rd_state_e         state_q, state_d;
  logic [NUM_M-1:0]  grant_q, grant_d;
  logic [NUM_M-1:0]  last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [NUM_M-1:0]  req, pick;
  logic              in_grant, in_wait, own_m1;
  logic              sel_arvalid, sel_rready, ar_hs, r_done;
  logic              route_m0, route_m1, raw_hold;

  assign req[M_IFU] = m0_rd.arvalid;
  assign req[M_LSU] = m1_rd.arvalid;

  ysyx_24110006_rr_pick #(.RR_EN(RR_EN)) u_pick (
    .req_i  (req),
    .last_i (last_grant_q),
    .gnt_o  (pick)
  );

  assign in_grant    = (state_q == ST_GRANT);
  assign in_wait     = (state_q == ST_WAIT_R);
  assign own_m1      = grant_q[M_LSU];
  assign sel_arvalid = own_m1 ? m1_rd.arvalid : m0_rd.arvalid;
  assign sel_rready  = own_m1 ? m1_rd.rready  : m0_rd.rready;
  assign ar_hs       = in_grant && sel_arvalid && axi_rd.arready;
  assign r_done      = in_wait && axi_rd.rvalid && sel_rready && axi_rd.rlast;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= NUM_M'(1) << M_IFU;
      araddr_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      araddr_q     <= araddr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    araddr_d     = araddr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_GRANT;
          grant_d  = pick;
          // Address is stable until its handshake, so latching it here keeps
          // a copy for the write-hazard compare after the master moves on.
          araddr_d = pick[M_LSU] ? m1_rd.araddr : m0_rd.araddr;
        end
      end
      ST_GRANT: begin
        if (ar_hs) state_d = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (r_done) begin
          state_d      = ST_IDLE;
          grant_d      = '0;
          last_grant_d = grant_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign o_rd_grant = grant_q;

  // AR: forward the owner's request only while in GRANT.
  assign axi_rd.arvalid = in_grant && sel_arvalid;
  assign axi_rd.araddr  = own_m1 ? m1_rd.araddr  : m0_rd.araddr;
  assign axi_rd.arid    = own_m1 ? m1_rd.arid    : m0_rd.arid;
  assign axi_rd.arlen   = own_m1 ? m1_rd.arlen   : m0_rd.arlen;
  assign axi_rd.arsize  = own_m1 ? m1_rd.arsize  : m0_rd.arsize;
  assign axi_rd.arburst = own_m1 ? m1_rd.arburst : m0_rd.arburst;
  assign m0_rd.arready  = in_grant && grant_q[M_IFU] && axi_rd.arready;
  assign m1_rd.arready  = in_grant && grant_q[M_LSU] && axi_rd.arready;

  // R: only the owner sees the response, and only in WAIT_R.
  assign route_m0      = in_wait && grant_q[M_IFU];
  assign route_m1      = in_wait && grant_q[M_LSU];
  assign axi_rd.rready = in_wait && sel_rready;

  assign m0_rd.rvalid = route_m0 && axi_rd.rvalid;
  assign m0_rd.rdata  = route_m0 ? axi_rd.rdata : '0;
  assign m0_rd.rresp  = route_m0 ? axi_rd.rresp : '0;
  assign m0_rd.rid    = route_m0 ? axi_rd.rid   : '0;
  assign m0_rd.rlast  = route_m0 && axi_rd.rlast;
  assign m1_rd.rvalid = route_m1 && axi_rd.rvalid;
  assign m1_rd.rdata  = route_m1 ? axi_rd.rdata : '0;
  assign m1_rd.rresp  = route_m1 ? axi_rd.rresp : '0;
  assign m1_rd.rid    = route_m1 ? axi_rd.rid   : '0;
  assign m1_rd.rlast  = route_m1 && axi_rd.rlast;

  // Write path: combinational pass-through. The handshake signals are also
  // gated by reset so nothing handshakes while the arbiter is held in reset.
  assign raw_hold = (state_q != ST_IDLE) && own_m1 && (araddr_q == m1_wr.awaddr);

  assign axi_wr.awvalid = i_reset && m1_wr.awvalid && !raw_hold;
  assign m1_wr.awready  = i_reset && axi_wr.awready && !raw_hold;
  assign axi_wr.awaddr  = m1_wr.awaddr;
  assign axi_wr.awid    = m1_wr.awid;
  assign axi_wr.awlen   = m1_wr.awlen;
  assign axi_wr.awsize  = m1_wr.awsize;
  assign axi_wr.awburst = m1_wr.awburst;
  assign axi_wr.wvalid  = i_reset && m1_wr.wvalid;
  assign m1_wr.wready   = i_reset && axi_wr.wready;
  assign axi_wr.wdata   = m1_wr.wdata;
  assign axi_wr.wstrb   = m1_wr.wstrb;
  assign axi_wr.wlast   = m1_wr.wlast;
  assign m1_wr.bvalid   = i_reset && axi_wr.bvalid;
  assign axi_wr.bready  = i_reset && m1_wr.bready;
  assign m1_wr.bresp    = axi_wr.bresp;
  assign m1_wr.bid      = axi_wr.bid;

endmodule

// File: tb/tb_ysyx_24110006_axi_arbiter.sv
// ----------------------------------------------------------------------------
// Bench for ysyx_24110006_axi_arbiter. The bench plays both requesters and the
// downstream slave. Expected grant order comes from a small model: the
// requester served last is remembered; on a collision the other one wins;
// reset makes the IFU the "last served".
// ----------------------------------------------------------------------------
module tb_ysyx_24110006_axi_arbiter;
  import ysyx_24110006_axi_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rd_grant;
  int         n_checks = 0;
  int         n_errors = 0;
  int         last_w = M_IFU;   // model: requester served most recently

  always #5 clk = ~clk;

  ysyx_24110006_axi_arbiter_rd_if m0_rd ();
  ysyx_24110006_axi_arbiter_rd_if m1_rd ();
  ysyx_24110006_axi_arbiter_rd_if ax_rd ();
  ysyx_24110006_axi_arbiter_wr_if m1_wr ();
  ysyx_24110006_axi_arbiter_wr_if ax_wr ();

  ysyx_24110006_axi_arbiter #(.NUM_M(2), .RR_EN(1)) u_dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .m0_rd      (m0_rd),
    .m1_rd      (m1_rd),
    .m1_wr      (m1_wr),
    .axi_rd     (ax_rd),
    .axi_wr     (ax_wr),
    .o_rd_grant (rd_grant)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic rv(input int m);
    return (m == M_LSU) ? m1_rd.rvalid : m0_rd.rvalid;
  endfunction

  function automatic logic ardy(input int m);
    return (m == M_LSU) ? m1_rd.arready : m0_rd.arready;
  endfunction

  task automatic set_ar(input int m, input logic v, input logic [31:0] a, input logic [7:0] l);
    if (m == M_LSU) begin
      m1_rd.arvalid = v; m1_rd.araddr = a; m1_rd.arlen = l; m1_rd.arid = 4'h2;
      m1_rd.arsize = 3'd2; m1_rd.arburst = 2'b01;
    end else begin
      m0_rd.arvalid = v; m0_rd.araddr = a; m0_rd.arlen = l; m0_rd.arid = 4'h1;
      m0_rd.arsize = 3'd2; m0_rd.arburst = 2'b01;
    end
  endtask

  // One arbitration round: requesters raise AR together, then each is served
  // in model order with a full R burst. Beat data = dbase + beat index.
  task automatic do_round(input bit r0, input bit r1, input logic [31:0] a0,
                          input logic [31:0] a1, input logic [7:0] l0,
                          input logic [7:0] l1, input logic [31:0] dbase,
                          input logic [1:0] resp);
    logic [31:0] addr [2];
    logic [7:0]  len  [2];
    int          order [$];
    int          first, w, o, lat;
    bit          match, hold, wv, bv;
    logic [1:0]  br;
    addr[0] = a0; addr[1] = a1; len[0] = l0; len[1] = l1;
    if (r0) set_ar(M_IFU, 1'b1, a0, l0);
    if (r1) set_ar(M_LSU, 1'b1, a1, l1);
    if (r0 && r1) begin
      first = (last_w == M_IFU) ? M_LSU : M_IFU;
      order.push_back(first);
      order.push_back(1 - first);
    end else begin
      order.push_back(r1 ? M_LSU : M_IFU);
    end
    foreach (order[k]) begin
      w = order[k];
      o = 1 - w;
      $display("txn: M%0d addr=0x%08h len=%0d resp=%0d", w, addr[w], len[w], resp);
      lat = 0;
      do begin
        cyc(); #1; lat++;
      end while (!ax_rd.arvalid && lat < 20);
      chk("ar_latency", lat, 1);
      chk("grant_owner", rd_grant, 64'(1) << w);
      chk("ar_addr", ax_rd.araddr, addr[w]);
      chk("ar_len", ax_rd.arlen, len[w]);
      chk("other_arready", ardy(o), 0);
      ax_rd.arready = 1'b1;
      #1;
      chk("owner_arready", ardy(w), 1);
      chk("other_arready_hs", ardy(o), 0);
      cyc();
      ax_rd.arready = 1'b0;
      set_ar(w, 1'b0, '0, '0);
      for (int b = 0; b <= int'(len[w]); b++) begin
        if ($urandom_range(0, 3) == 0) begin
          ax_rd.rvalid = 1'b0;
          #1;
          chk("rvalid_gap", rv(w), 0);
          cyc();
        end
        ax_rd.rvalid = 1'b1;
        ax_rd.rdata  = dbase + 32'(b);
        ax_rd.rresp  = resp;
        ax_rd.rid    = (w == M_LSU) ? 4'h2 : 4'h1;
        ax_rd.rlast  = (b == int'(len[w]));
        match = 1'($urandom_range(0, 1));
        wv = 1'($urandom_range(0, 1));
        bv = 1'($urandom_range(0, 1));
        br = 2'($urandom_range(0, 3));
        m1_wr.awaddr  = match ? addr[w] : addr[w] + 32'd4;
        m1_wr.awvalid = 1'b1;
        m1_wr.wvalid  = wv;
        ax_wr.awready = 1'b1;
        ax_wr.bvalid  = bv;
        ax_wr.bresp   = br;
        #1;
        hold = (w == M_LSU) && match;
        chk("r_owner_valid", rv(w), 1);
        chk("r_other_valid", rv(o), 0);
        chk("r_data", (w == M_LSU) ? m1_rd.rdata : m0_rd.rdata, dbase + 32'(b));
        chk("r_resp", (w == M_LSU) ? m1_rd.rresp : m0_rd.rresp, resp);
        chk("r_last", (w == M_LSU) ? m1_rd.rlast : m0_rd.rlast, b == int'(len[w]));
        chk("ax_rready", ax_rd.rready, 1);
        chk("grant_hold", rd_grant, 64'(1) << w);
        chk("other_arready_r", ardy(o), 0);
        chk("aw_valid", ax_wr.awvalid, !hold);
        chk("aw_ready", m1_wr.awready, !hold);
        chk("w_valid", ax_wr.wvalid, wv);
        chk("b_valid", m1_wr.bvalid, bv);
        chk("b_resp", m1_wr.bresp, br);
        cyc();
      end
      ax_rd.rvalid = 1'b0;
      ax_rd.rlast  = 1'b0;
      m1_wr.awaddr = addr[w];
      #1;
      chk("grant_idle", rd_grant, 0);
      chk("aw_after_read", ax_wr.awvalid, 1);
      m1_wr.awvalid = 1'b0;
      m1_wr.wvalid  = 1'b0;
      ax_wr.bvalid  = 1'b0;
      last_w = w;
    end
  endtask

  // LSU burst interrupted by reset during beat 2.
  task automatic reset_mid_burst();
    int lat;
    $display("txn: M1 addr=0x80000100 len=3 with reset during beat 2");
    set_ar(M_LSU, 1'b1, 32'h8000_0100, 8'd3);
    lat = 0;
    do begin
      cyc(); #1; lat++;
    end while (!ax_rd.arvalid && lat < 20);
    chk("rst_ar_latency", lat, 1);
    chk("rst_grant", rd_grant, 2'b10);
    ax_rd.arready = 1'b1;
    cyc();
    ax_rd.arready = 1'b0;
    set_ar(M_LSU, 1'b0, '0, '0);
    for (int b = 0; b < 2; b++) begin
      ax_rd.rvalid = 1'b1; ax_rd.rdata = 32'h100 + 32'(b); ax_rd.rlast = 1'b0;
      cyc();
    end
    m1_wr.awvalid = 1'b1; m1_wr.awaddr = 32'h1234_0000; m1_wr.wvalid = 1'b1;
    ax_wr.awready = 1'b1; ax_wr.wready = 1'b1; ax_wr.bvalid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_grant_zero", rd_grant, 0);
    chk("rst_m1_rvalid", m1_rd.rvalid, 0);
    chk("rst_m0_rvalid", m0_rd.rvalid, 0);
    chk("rst_ax_arvalid", ax_rd.arvalid, 0);
    chk("rst_ax_rready", ax_rd.rready, 0);
    chk("rst_ax_awvalid", ax_wr.awvalid, 0);
    chk("rst_ax_wvalid", ax_wr.wvalid, 0);
    chk("rst_m1_awready", m1_wr.awready, 0);
    chk("rst_m1_wready", m1_wr.wready, 0);
    chk("rst_m1_bvalid", m1_wr.bvalid, 0);
    m1_wr.awvalid = 1'b0; m1_wr.wvalid = 1'b0;
    ax_wr.awready = 1'b0; ax_wr.wready = 1'b0; ax_wr.bvalid = 1'b0;
    cyc();
    rst_n = 1'b1;
    last_w = M_IFU;
    for (int b = 2; b < 4; b++) begin
      ax_rd.rvalid = 1'b1; ax_rd.rdata = 32'h100 + 32'(b); ax_rd.rlast = (b == 3);
      #1;
      chk("post_rst_rvalid", m1_rd.rvalid, 0);
      chk("post_rst_rready", ax_rd.rready, 0);
      chk("post_rst_grant", rd_grant, 0);
      cyc();
    end
    ax_rd.rvalid = 1'b0; ax_rd.rlast = 1'b0;
  endtask

  initial begin
    int pat;
    set_ar(M_IFU, 1'b0, '0, '0);
    set_ar(M_LSU, 1'b0, '0, '0);
    m0_rd.rready = 1'b1; m1_rd.rready = 1'b1;
    ax_rd.arready = 1'b0; ax_rd.rvalid = 1'b0; ax_rd.rdata = '0;
    ax_rd.rresp = '0; ax_rd.rid = '0; ax_rd.rlast = 1'b0;
    m1_wr.awaddr = '0; m1_wr.awvalid = 1'b0; m1_wr.awid = 4'h2; m1_wr.awlen = '0;
    m1_wr.awsize = 3'd2; m1_wr.awburst = 2'b01; m1_wr.wdata = 32'h5A5A_0000;
    m1_wr.wstrb = 4'hF; m1_wr.wlast = 1'b1; m1_wr.wvalid = 1'b0; m1_wr.bready = 1'b1;
    ax_wr.awready = 1'b0; ax_wr.wready = 1'b1; ax_wr.bvalid = 1'b0;
    ax_wr.bresp = '0; ax_wr.bid = 4'h2;

    // Reset state, with activity on every input that could leak through.
    m0_rd.arvalid = 1'b1; ax_rd.rvalid = 1'b1; m1_wr.awvalid = 1'b1;
    m1_wr.wvalid = 1'b1; ax_wr.awready = 1'b1; ax_wr.bvalid = 1'b1;
    cyc(); cyc(); #1;
    chk("reset_grant", rd_grant, 0);
    chk("reset_ax_arvalid", ax_rd.arvalid, 0);
    chk("reset_m0_arready", m0_rd.arready, 0);
    chk("reset_m0_rvalid", m0_rd.rvalid, 0);
    chk("reset_ax_rready", ax_rd.rready, 0);
    chk("reset_ax_awvalid", ax_wr.awvalid, 0);
    chk("reset_ax_wvalid", ax_wr.wvalid, 0);
    chk("reset_m1_awready", m1_wr.awready, 0);
    chk("reset_m1_bvalid", m1_wr.bvalid, 0);
    m0_rd.arvalid = 1'b0; ax_rd.rvalid = 1'b0; m1_wr.awvalid = 1'b0;
    m1_wr.wvalid = 1'b0; ax_wr.awready = 1'b0; ax_wr.bvalid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Single IFU read.
    do_round(1, 0, 32'h3000_0000, 32'h0, 8'd0, 8'd0, 32'hDEAD_BEEF, 2'b00);
    // Collision: LSU burst of 4 to a hazard address while IFU waits.
    do_round(1, 1, 32'h3000_0040, 32'h8000_0010, 8'd0, 8'd3, 32'h1111_0000, 2'b00);
    // LSU alone, then a collision that the IFU must win.
    do_round(0, 1, 32'h0, 32'h8000_0020, 8'd0, 8'd1, 32'h2222_0000, 2'b00);
    do_round(1, 1, 32'h3000_0080, 32'h8000_0030, 8'd1, 8'd0, 32'h3333_0000, 2'b00);
    // Error response on an IFU read.
    do_round(1, 0, 32'h3000_00C0, 32'h0, 8'd0, 8'd0, 32'h4444_0000, 2'b10);

    for (int i = 0; i < 20; i++) begin
      pat = int'($urandom_range(1, 3));
      do_round(pat[0], pat[1], $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), $urandom,
               2'($urandom_range(0, 3)));
    end

    do_round(0, 1, 32'h0, 32'h8000_0200, 8'd0, 8'd0, 32'h5555_0000, 2'b00);
    reset_mid_burst();
    // After reset the LSU must win a collision again.
    do_round(1, 1, 32'h3000_0300, 32'h8000_0300, 8'd1, 8'd1, 32'h6666_0000, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
